// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: icodes, status codes, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_ACCESS = 2'd1,
    MS_RESP   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_addr_ctrl.sv
// Decodes icode/valA/valE/valP into memory direction, address, write data and range fault.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on the stage inputs.
module mem_addr_ctrl
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 8192
) (
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        is_read,
  output logic        is_write,
  output logic [63:0] addr,
  output logic [63:0] wdata,
  output logic        addr_fault
);

  // Highest byte address at which a full 8-byte access still fits.
  localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);

  // Classify the instruction and pick its address and store data source.
  always_comb begin
    is_read    = 1'b0;
    is_write   = 1'b0;
    addr       = 64'd0;
    wdata      = 64'd0;
    case (icode)
      I_MRMOVQ: begin
        is_read = 1'b1;
        addr    = valE;
      end
      I_POPQ, I_RET: begin
        is_read = 1'b1;
        addr    = valA;
      end
      I_RMMOVQ, I_PUSHQ: begin
        is_write = 1'b1;
        addr     = valE;
        wdata    = valA;
      end
      I_CALL: begin
        is_write = 1'b1;
        addr     = valE;
        wdata    = valP;
      end
      default: ;
    endcase
    addr_fault = (is_read || is_write) && (addr > ADDR_MAX);
  end

endmodule

// File: rtl/mem_access_stage.sv
// Y86-64 memory stage: one instruction at a time, req/ack data memory, one-cycle result strobe.
// Latency: 1 cycle for non-memory ops, ack edge + 1 for memory ops (min 2); all outputs registered.
// Backpressure: in_ready low outside IDLE and forever after a fault or halt; optional perf
// counters are enabled with `define MEM_ACCESS_PERF_EN.
module mem_access_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES     = 8192,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_rA,
  input  logic [3:0]  in_rB,
  input  logic [63:0] in_valA,
  input  logic [63:0] in_valE,
  input  logic [63:0] in_valP,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        out_valid,
  output logic [3:0]  out_icode,
  output logic [3:0]  out_rA,
  output logic [3:0]  out_rB,
  output logic [63:0] out_valE,
  output logic [63:0] out_valM,
  output logic [2:0]  stat
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_wait_cycles
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic        halted_q, halted_d;
  logic [7:0]  wait_cnt_q;
  logic [3:0]  lat_icode_q, lat_rA_q, lat_rB_q;
  logic [63:0] lat_valE_q;
  logic        lat_read_q;

  logic        dec_is_read, dec_is_write, dec_addr_fault;
  logic [63:0] dec_addr, dec_wdata;

  logic        start_access, end_access, cnt_inc, resp_load;
  logic [2:0]  resp_stat;
  logic [63:0] resp_valM;
  logic [3:0]  src_icode, src_rA, src_rB;
  logic [63:0] src_valE;

  mem_addr_ctrl #(.DMEM_BYTES(DMEM_BYTES)) u_addr_ctrl (
    .icode      (in_icode),
    .valA       (in_valA),
    .valE       (in_valE),
    .valP       (in_valP),
    .is_read    (dec_is_read),
    .is_write   (dec_is_write),
    .addr       (dec_addr),
    .wdata      (dec_wdata),
    .addr_fault (dec_addr_fault)
  );

  // Result fields come straight from the inputs when resolved at accept, else from the latch.
  always_comb begin
    src_icode = lat_icode_q;
    src_rA    = lat_rA_q;
    src_rB    = lat_rB_q;
    src_valE  = lat_valE_q;
    if (state_q == MS_IDLE) begin
      src_icode = in_icode;
      src_rA    = in_rA;
      src_rB    = in_rB;
      src_valE  = in_valE;
    end
  end

  // Next-state logic and per-cycle control strobes for the registered outputs.
  always_comb begin
    state_d      = state_q;
    start_access = 1'b0;
    end_access   = 1'b0;
    cnt_inc      = 1'b0;
    resp_load    = 1'b0;
    resp_stat    = STAT_AOK;
    resp_valM    = 64'd0;
    case (state_q)
      MS_IDLE: begin
        if (in_valid && in_ready) begin
          if (in_icode == I_HALT) begin
            resp_load = 1'b1;
            resp_stat = STAT_HLT;
          end else if (in_icode > I_POPQ) begin
            resp_load = 1'b1;
            resp_stat = STAT_INS;
          end else if (dec_is_read || dec_is_write) begin
            if (dec_addr_fault) begin
              resp_load = 1'b1;
              resp_stat = STAT_ADR;
            end else begin
              start_access = 1'b1;
              state_d      = MS_ACCESS;
            end
          end else begin
            resp_load = 1'b1;
          end
          if (resp_load) state_d = MS_RESP;
        end
      end
      MS_ACCESS: begin
        if (dmem_ack) begin
          end_access = 1'b1;
          resp_load  = 1'b1;
          state_d    = MS_RESP;
          if (dmem_err) begin
            resp_stat = STAT_ADR;
          end else if (lat_read_q) begin
            resp_valM = dmem_rdata;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          end_access = 1'b1;
          resp_load  = 1'b1;
          resp_stat  = STAT_ADR;
          state_d    = MS_RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      MS_RESP: begin
        state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
    halted_d = halted_q || ((state_q == MS_RESP) && (stat != STAT_AOK));
  end

  // FSM state, sticky halt flag and registered accept handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_IDLE;
      halted_q <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      in_ready <= (state_d == MS_IDLE) && !halted_d;
    end
  end

  // Latch the instruction at accept so it survives the memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_icode_q <= I_NOP;
      lat_rA_q    <= R_NONE;
      lat_rB_q    <= R_NONE;
      lat_valE_q  <= 64'd0;
      lat_read_q  <= 1'b0;
    end else if (state_q == MS_IDLE && in_valid && in_ready) begin
      lat_icode_q <= in_icode;
      lat_rA_q    <= in_rA;
      lat_rB_q    <= in_rB;
      lat_valE_q  <= in_valE;
      lat_read_q  <= dec_is_read;
    end
  end

  // Memory port: request held with stable address/data until ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      if (start_access) begin
        dmem_req   <= 1'b1;
        dmem_we    <= dec_is_write;
        dmem_addr  <= dec_addr;
        dmem_wdata <= dec_wdata;
        wait_cnt_q <= 8'd0;
      end else if (end_access) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end else if (cnt_inc) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  // Write-back interface: a one-cycle strobe, icode parked at nop whenever not strobing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= I_NOP;
      out_rA    <= R_NONE;
      out_rB    <= R_NONE;
      out_valE  <= 64'd0;
      out_valM  <= 64'd0;
      stat      <= STAT_AOK;
    end else if (resp_load) begin
      out_valid <= 1'b1;
      out_icode <= (resp_stat == STAT_AOK) ? src_icode : I_NOP;
      out_rA    <= src_rA;
      out_rB    <= src_rB;
      out_valE  <= src_valE;
      out_valM  <= resp_valM;
      stat      <= resp_stat;
    end else begin
      out_valid <= 1'b0;
      out_icode <= I_NOP;
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  // Saturating event counters for successful loads, stores and ack-less wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads       <= 32'd0;
      perf_stores      <= 32'd0;
      perf_wait_cycles <= 32'd0;
    end else if (state_q == MS_ACCESS) begin
      if (dmem_ack && !dmem_err && lat_read_q && perf_loads != 32'hFFFF_FFFF)
        perf_loads <= perf_loads + 32'd1;
      if (dmem_ack && !dmem_err && !lat_read_q && perf_stores != 32'hFFFF_FFFF)
        perf_stores <= perf_stores + 32'd1;
      if (!dmem_ack && perf_wait_cycles != 32'hFFFF_FFFF)
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, random vs reference model,
// hand-written reset-mid-access sequence.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_icode = 4'h1, in_rA = 4'hF, in_rB = 4'hF;
  logic [63:0] in_valA = '0, in_valE = '0, in_valP = '0;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = '0;
  logic        dmem_err = 1'b0;
  logic        out_valid;
  logic [3:0]  out_icode, out_rA, out_rB;
  logic [63:0] out_valE, out_valM;
  logic [2:0]  stat;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.DMEM_BYTES(8192), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
    .in_valA(in_valA), .in_valE(in_valE), .in_valP(in_valP),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .out_valid(out_valid), .out_icode(out_icode), .out_rA(out_rA), .out_rB(out_rB),
    .out_valE(out_valE), .out_valM(out_valM), .stat(stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mem;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          reqc;   // cycles dmem_req is high
    logic [2:0]  stat;
    logic [3:0]  ocode;
    logic [63:0] valM;
  } exp_t;

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [63:0] valA, valE, valP;
    int          dly;    // req cycles before ack; >=16 means never ack
    bit          err;
    logic [63:0] rdata;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: derived from the Y86 memory-stage rules, not from the RTL structure.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    bit rd, wr;
    rd = v.icode inside {4'h5, 4'h9, 4'hB};
    wr = v.icode inside {4'h4, 4'h8, 4'hA};
    e.mem = 0; e.we = wr; e.reqc = 0; e.valM = 0;
    e.addr  = (v.icode == 4'h9 || v.icode == 4'hB) ? v.valA : v.valE;
    e.wdata = (v.icode == 4'h8) ? v.valP : v.valA;
    e.stat  = 3'd1;
    if (v.icode == 4'h0) e.stat = 3'd2;
    else if (v.icode > 4'hB) e.stat = 3'd4;
    else if ((rd || wr) && e.addr > 64'd8184) e.stat = 3'd3;
    else if (rd || wr) begin
      e.mem = 1;
      if (v.dly < 16) begin
        e.reqc = v.dly + 1;
        if (v.err) e.stat = 3'd3;
        else if (rd) e.valM = v.rdata;
      end else begin
        e.reqc = 16;
        e.stat = 3'd3;
      end
    end
    e.ocode = (e.stat == 3'd1) ? v.icode : 4'h1;
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] ic, ra, rb, input logic [63:0] va, ve, vp,
                              input int dly, input bit err, input logic [63:0] rd,
                              input bit mem, we, input logic [63:0] addr, wd, input int reqc,
                              input logic [2:0] st, input logic [3:0] oc, input logic [63:0] vm);
    vec_t v;
    v.icode = ic; v.rA = ra; v.rB = rb; v.valA = va; v.valE = ve; v.valP = vp;
    v.dly = dly; v.err = err; v.rdata = rd;
    v.e.mem = mem; v.e.we = we; v.e.addr = addr; v.e.wdata = wd; v.e.reqc = reqc;
    v.e.stat = st; v.e.ocode = oc; v.e.valM = vm;
    return v;
  endfunction

  task automatic do_reset();
    in_valid = 0; dmem_ack = 0; dmem_err = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Issue one instruction at a negedge, act as memory, and check every cycle until done.
  task automatic run(input vec_t v);
    int lat, bad_win, bad_bus;
    exp_t e;
    e = v.e;
    lat = e.mem ? e.reqc + 1 : 1;
    bad_win = 0; bad_bus = 0;
    chk("in_ready_before", in_ready, 1);
    in_valid = 1; in_icode = v.icode; in_rA = v.rA; in_rB = v.rB;
    in_valA = v.valA; in_valE = v.valE; in_valP = v.valP;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      if (cyc > 1) @(negedge clk);
      dmem_ack = 0; dmem_err = 0;
      if (cyc < lat) begin
        if (out_valid !== 1'b0 || out_icode !== 4'h1) bad_win++;
        if (dmem_req !== (e.mem && cyc <= e.reqc)) bad_win++;
        if (dmem_req === 1'b1) begin
          if (dmem_addr !== e.addr || dmem_we !== e.we) bad_bus++;
          if (e.we && dmem_wdata !== e.wdata) bad_bus++;
        end
        if (e.mem && v.dly < 16 && cyc == v.dly + 1) begin
          dmem_ack = 1; dmem_err = v.err; dmem_rdata = v.rdata;
        end
      end else if (cyc == lat) begin
        chk("req_window", bad_win, 0);
        chk("mem_bus", bad_bus, 0);
        chk("out_valid", out_valid, 1);
        chk("out_icode", out_icode, e.ocode);
        chk("out_rA", out_rA, v.rA);
        chk("out_rB", out_rB, v.rB);
        chk("out_valE", out_valE, v.valE);
        chk("out_valM", out_valM, e.valM);
        chk("stat", stat, e.stat);
        chk("req_off_at_resp", dmem_req, 0);
      end else begin
        chk("strobe_one_cycle", {out_valid, out_icode}, {1'b0, 4'h1});
        chk("in_ready_after", in_ready, (e.stat == 3'd1));
      end
    end
    if (e.stat != 3'd1) begin
      repeat (3) @(negedge clk);
      chk("halt_sticky", {in_ready, stat}, {1'b0, e.stat});
      do_reset();
    end
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = mk(4'h3, 4'hF, 4'h2, 64'h0,    64'h2A,   64'h0,  0, 0, 64'h0,
                 0, 0, 64'h0, 64'h0, 0, 3'd1, 4'h3, 64'h0);
    tbl[1]  = mk(4'h5, 4'h3, 4'h4, 64'h0,    64'h100,  64'h0,  2, 0, 64'hDEADBEEF,
                 1, 0, 64'h100, 64'h0, 3, 3'd1, 4'h5, 64'hDEADBEEF);
    tbl[2]  = mk(4'hA, 4'h5, 4'hF, 64'h55,   64'h1F8,  64'h0,  0, 0, 64'h0,
                 1, 1, 64'h1F8, 64'h55, 1, 3'd1, 4'hA, 64'h0);
    tbl[3]  = mk(4'h8, 4'hF, 4'h4, 64'h0,    64'h1F0,  64'h40, 1, 0, 64'h0,
                 1, 1, 64'h1F0, 64'h40, 2, 3'd1, 4'h8, 64'h0);
    tbl[4]  = mk(4'h4, 4'h1, 4'h2, 64'h77,   64'h1FF8, 64'h0,  0, 0, 64'h0,
                 1, 1, 64'h1FF8, 64'h77, 1, 3'd1, 4'h4, 64'h0);
    tbl[5]  = mk(4'h6, 4'h1, 4'h2, 64'h0,    64'h1234, 64'h0,  0, 0, 64'h0,
                 0, 0, 64'h0, 64'h0, 0, 3'd1, 4'h6, 64'h0);
    tbl[6]  = mk(4'h5, 4'h6, 4'h7, 64'h0,    64'h200,  64'h0,  1, 1, 64'h99,
                 1, 0, 64'h200, 64'h0, 2, 3'd3, 4'h1, 64'h0);
    tbl[7]  = mk(4'hB, 4'h8, 4'hF, 64'h1FFF, 64'h0,    64'h0,  0, 0, 64'h0,
                 0, 0, 64'h0, 64'h0, 0, 3'd3, 4'h1, 64'h0);
    tbl[8]  = mk(4'h9, 4'hF, 4'hF, 64'h1FF9, 64'h0,    64'h0,  0, 0, 64'h0,
                 0, 0, 64'h0, 64'h0, 0, 3'd3, 4'h1, 64'h0);
    tbl[9]  = mk(4'h0, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,  0, 0, 64'h0,
                 0, 0, 64'h0, 64'h0, 0, 3'd2, 4'h1, 64'h0);
    tbl[10] = mk(4'hC, 4'h1, 4'h1, 64'h0,    64'h0,    64'h0,  0, 0, 64'h0,
                 0, 0, 64'h0, 64'h0, 0, 3'd4, 4'h1, 64'h0);
    tbl[11] = mk(4'h5, 4'h2, 4'h3, 64'h0,    64'h80,   64'h0, 99, 0, 64'h0,
                 1, 0, 64'h80, 64'h0, 16, 3'd3, 4'h1, 64'h0);

    // Reset state while rst_n is held low, then after release.
    #12;
    chk("rst_stat", stat, 3'd1);
    chk("rst_out_icode", out_icode, 4'h1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_regs", {out_rA, out_rB}, 8'hFF);
    chk("rst_vals", {out_valE, out_valM, dmem_addr}, 192'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Directed table.
    for (int i = 0; i < 12; i++) run(tbl[i]);

    // Reset asserted in the middle of an access, then a stray late ack.
    in_valid = 1; in_icode = 4'h5; in_rA = 4'h1; in_rB = 4'h2; in_valE = 64'h300;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_req_high", dmem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_req_drop", dmem_req, 0);
    chk("mid_rst_stat", stat, 3'd1);
    chk("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 64'h1234_5678;
    @(negedge clk);
    dmem_ack = 0;
    chk("late_ack_ignored", {out_valid, dmem_req, out_icode}, {1'b0, 1'b0, 4'h1});
    @(negedge clk);
    chk("late_ack_idle", {out_valid, in_ready, stat}, {1'b0, 1'b1, 3'd1});

    // Randomized instructions checked against the reference model.
    for (int n = 0; n < 60; n++) begin
      int r;
      rv.icode = 4'($urandom_range(0, 15));
      rv.rA = 4'($urandom_range(0, 15));
      rv.rB = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        logic [63:0] a;
        case ($urandom_range(0, 3))
          0: a = 64'($urandom_range(0, 8184));
          1: a = 64'(8184 + $urandom_range(0, 15));
          2: a = {$urandom, $urandom};
          default: a = 64'($urandom_range(0, 1023)) << 3;
        endcase
        if (k == 0) rv.valA = a; else rv.valE = a;
      end
      rv.valP = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      rv.dly = (r == 9) ? 30 : r % 5;
      rv.err = ($urandom_range(0, 7) == 0);
      rv.rdata = {$urandom, $urandom};
      rv.e = model(rv);
      run(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
